// File: rtl/ret_stack_ctl_if.sv
// Request, stack-side and response signals of the shared return-stack controller.
// The requester/stack side uses the master modport; the controller uses the slave modport. Optional ovf/unf counters are present only when RSTACK_CTL_STATS_EN is defined.
interface ret_stack_ctl_if #(
    parameter int DATA_WIDTH = 67,
    parameter int CNT_WIDTH  = 5
);
    logic                  except;
    logic                  except_thread;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_pop;
    logic [DATA_WIDTH-1:0] req_data0;
    logic [DATA_WIDTH-1:0] req_data1;
    logic [4:0]            req_lnk0;
    logic [4:0]            req_lnk1;
    logic [1:0]            req_trace;
    logic                  stk_except;
    logic                  stk_except_thread;
    logic                  stk_read_clkEn;
    logic                  stk_write_wen;
    logic                  stk_thread;
    logic [DATA_WIDTH-1:0] stk_write_data;
    logic [4:0]            stk_write_lnk;
    logic                  stk_write_trace;
    logic                  rsp_valid;
    logic                  rsp_thread;
    logic                  rsp_hit;
    logic [CNT_WIDTH-1:0]  depth0;
    logic [CNT_WIDTH-1:0]  depth1;
`ifdef RSTACK_CTL_STATS_EN
    logic [15:0]           ovf_cnt;
    logic [15:0]           unf_cnt;
`endif

    modport master (
`ifdef RSTACK_CTL_STATS_EN
        input  ovf_cnt, unf_cnt,
`endif
        output except, except_thread, req_valid, req_pop, req_data0, req_data1,
               req_lnk0, req_lnk1, req_trace,
        input  req_ready, stk_except, stk_except_thread, stk_read_clkEn, stk_write_wen,
               stk_thread, stk_write_data, stk_write_lnk, stk_write_trace,
               rsp_valid, rsp_thread, rsp_hit, depth0, depth1
    );

    modport slave (
`ifdef RSTACK_CTL_STATS_EN
        output ovf_cnt, unf_cnt,
`endif
        input  except, except_thread, req_valid, req_pop, req_data0, req_data1,
               req_lnk0, req_lnk1, req_trace,
        output req_ready, stk_except, stk_except_thread, stk_read_clkEn, stk_write_wen,
               stk_thread, stk_write_data, stk_write_lnk, stk_write_trace,
               rsp_valid, rsp_thread, rsp_hit, depth0, depth1
    );
endinterface

// File: rtl/ret_stack_ctl.sv
// Two-thread return-stack sequencer: 2-entry FIFO per thread, round-robin grant, stack op 1 cycle after grant, pop rsp 1 cycle after that.
// Backpressure via registered req_ready (FIFO count < 2); RSTACK_CTL_STATS_EN adds saturating ovf_cnt/unf_cnt.
module ret_stack_ctl #(
    parameter int DATA_WIDTH = 67,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic           clk,
    input  logic           rst,
    ret_stack_ctl_if.slave bus
);

    typedef struct packed {
        logic                  pop;
        logic [DATA_WIDTH-1:0] data;
        logic [4:0]            lnk;
        logic                  trace;
    } req_t;

    localparam logic [CNT_WIDTH-1:0] DEPTH_MAX = CNT_WIDTH'(DEPTH);

    req_t                 fifo_mem_q [2][2];
    req_t                 fifo_mem_d [2][2];
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           cnt_q [2];
    logic [1:0]           cnt_d [2];
    logic [1:0]           ready_q, ready_d;
    logic [CNT_WIDTH-1:0] depth_q [2];
    logic [CNT_WIDTH-1:0] depth_d [2];
    logic                 prio_q, prio_d;

    logic                  stk_except_q, stk_except_d;
    logic                  stk_except_thread_q, stk_except_thread_d;
    logic                  stk_read_clken_q, stk_read_clken_d;
    logic                  stk_write_wen_q, stk_write_wen_d;
    logic                  stk_thread_q, stk_thread_d;
    logic [DATA_WIDTH-1:0] stk_write_data_q, stk_write_data_d;
    logic [4:0]            stk_write_lnk_q, stk_write_lnk_d;
    logic                  stk_write_trace_q, stk_write_trace_d;
    logic                  pend_hit_q, pend_hit_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_thread_q, rsp_thread_d;
    logic                  rsp_hit_q, rsp_hit_d;
`ifdef RSTACK_CTL_STATS_EN
    logic [15:0]           ovf_cnt_q, ovf_cnt_d;
    logic [15:0]           unf_cnt_q, unf_cnt_d;
`endif

    req_t                 in_req [2];
    req_t                 head   [2];
    req_t                 gnt_head;
    logic [1:0]           nempty, flush, enq, deq;
    logic                 gnt_vld, gnt_thr, gnt_push, gnt_pop;
    logic [CNT_WIDTH-1:0] gnt_depth;

    always_comb begin
        in_req[0] = '{pop: bus.req_pop[0], data: bus.req_data0, lnk: bus.req_lnk0, trace: bus.req_trace[0]};
        in_req[1] = '{pop: bus.req_pop[1], data: bus.req_data1, lnk: bus.req_lnk1, trace: bus.req_trace[1]};
        head[0]   = fifo_mem_q[0][rd_ptr_q[0]];
        head[1]   = fifo_mem_q[1][rd_ptr_q[1]];
        nempty    = {cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};

        // A flush in this cycle blocks every grant, not only the flushed thread's.
        gnt_vld   = ~bus.except & (|nempty);
        gnt_thr   = (&nempty) ? prio_q : nempty[1];
        gnt_head  = head[gnt_thr];
        gnt_depth = depth_q[gnt_thr];
        gnt_push  = gnt_vld & ~gnt_head.pop;
        gnt_pop   = gnt_vld & gnt_head.pop;

        fifo_mem_d = fifo_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        depth_d    = depth_q;
        ready_d    = ready_q;
        flush      = '0;
        enq        = '0;
        deq        = '0;

        for (int t = 0; t < 2; t++) begin
            flush[t] = bus.except & (bus.except_thread == 1'(t));
            enq[t]   = bus.req_valid[t] & ready_q[t] & ~flush[t];
            deq[t]   = gnt_vld & (gnt_thr == 1'(t));
            if (enq[t]) begin
                fifo_mem_d[t][wr_ptr_q[t]] = in_req[t];
            end
            if (flush[t]) begin
                rd_ptr_d[t] = 1'b0;
                wr_ptr_d[t] = 1'b0;
                cnt_d[t]    = 2'd0;
                depth_d[t]  = '0;
            end else begin
                rd_ptr_d[t] = rd_ptr_q[t] ^ deq[t];
                wr_ptr_d[t] = wr_ptr_q[t] ^ enq[t];
                cnt_d[t]    = cnt_q[t] + 2'(enq[t]) - 2'(deq[t]);
                // Push at capacity drops the oldest entry, so the count saturates.
                if (deq[t] && !head[t].pop && depth_q[t] != DEPTH_MAX) begin
                    depth_d[t] = depth_q[t] + 1'b1;
                end else if (deq[t] && head[t].pop && depth_q[t] != '0) begin
                    depth_d[t] = depth_q[t] - 1'b1;
                end
            end
            ready_d[t] = (cnt_d[t] != 2'd2);
        end

        prio_d = gnt_vld ? ~gnt_thr : prio_q;

        stk_except_d        = bus.except;
        stk_except_thread_d = bus.except ? bus.except_thread : stk_except_thread_q;
        stk_write_wen_d     = gnt_push;
        stk_read_clken_d    = gnt_pop;
        stk_thread_d        = gnt_vld ? gnt_thr : stk_thread_q;
        stk_write_data_d    = gnt_push ? gnt_head.data  : stk_write_data_q;
        stk_write_lnk_d     = gnt_push ? gnt_head.lnk   : stk_write_lnk_q;
        stk_write_trace_d   = gnt_push ? gnt_head.trace : stk_write_trace_q;
        pend_hit_d          = gnt_pop ? (gnt_depth != '0) : pend_hit_q;

        // The pop strobe currently on the stack becomes next cycle's response unless its thread is flushed now.
        rsp_valid_d  = stk_read_clken_q & ~(bus.except & (bus.except_thread == stk_thread_q));
        rsp_thread_d = stk_read_clken_q ? stk_thread_q : rsp_thread_q;
        rsp_hit_d    = stk_read_clken_q ? pend_hit_q   : rsp_hit_q;

`ifdef RSTACK_CTL_STATS_EN
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (gnt_push && gnt_depth == DEPTH_MAX && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
        if (gnt_pop && gnt_depth == '0 && unf_cnt_q != 16'hFFFF) begin
            unf_cnt_d = unf_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q            <= '0;
            wr_ptr_q            <= '0;
            cnt_q               <= '{default: '0};
            depth_q             <= '{default: '0};
            ready_q             <= 2'b11;
            prio_q              <= 1'b0;
            stk_except_q        <= 1'b0;
            stk_except_thread_q <= 1'b0;
            stk_read_clken_q    <= 1'b0;
            stk_write_wen_q     <= 1'b0;
            stk_thread_q        <= 1'b0;
            stk_write_data_q    <= '0;
            stk_write_lnk_q     <= '0;
            stk_write_trace_q   <= 1'b0;
            pend_hit_q          <= 1'b0;
            rsp_valid_q         <= 1'b0;
            rsp_thread_q        <= 1'b0;
            rsp_hit_q           <= 1'b0;
        end else begin
            rd_ptr_q            <= rd_ptr_d;
            wr_ptr_q            <= wr_ptr_d;
            cnt_q               <= cnt_d;
            depth_q             <= depth_d;
            ready_q             <= ready_d;
            prio_q              <= prio_d;
            stk_except_q        <= stk_except_d;
            stk_except_thread_q <= stk_except_thread_d;
            stk_read_clken_q    <= stk_read_clken_d;
            stk_write_wen_q     <= stk_write_wen_d;
            stk_thread_q        <= stk_thread_d;
            stk_write_data_q    <= stk_write_data_d;
            stk_write_lnk_q     <= stk_write_lnk_d;
            stk_write_trace_q   <= stk_write_trace_d;
            pend_hit_q          <= pend_hit_d;
            rsp_valid_q         <= rsp_valid_d;
            rsp_thread_q        <= rsp_thread_d;
            rsp_hit_q           <= rsp_hit_d;
        end
    end

`ifdef RSTACK_CTL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign bus.ovf_cnt = ovf_cnt_q;
    assign bus.unf_cnt = unf_cnt_q;
`endif

    assign bus.req_ready         = ready_q;
    assign bus.stk_except        = stk_except_q;
    assign bus.stk_except_thread = stk_except_thread_q;
    assign bus.stk_read_clkEn    = stk_read_clken_q;
    assign bus.stk_write_wen     = stk_write_wen_q;
    assign bus.stk_thread        = stk_thread_q;
    assign bus.stk_write_data    = stk_write_data_q;
    assign bus.stk_write_lnk     = stk_write_lnk_q;
    assign bus.stk_write_trace   = stk_write_trace_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_thread        = rsp_thread_q;
    assign bus.rsp_hit           = rsp_hit_q;
    assign bus.depth0            = depth_q[0];
    assign bus.depth1            = depth_q[1];

endmodule

// File: tb/tb_ret_stack_ctl.sv
// Directed bench for ret_stack_ctl: push/pop/underflow, alternation, saturation, backpressure, flush, mid-stream reset.
// Optional counters are checked when RSTACK_CTL_STATS_EN is defined.
module tb_ret_stack_ctl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ret_stack_ctl_if #(.DATA_WIDTH(67), .CNT_WIDTH(5)) bus ();

    ret_stack_ctl #(.DATA_WIDTH(67), .DEPTH(16), .CNT_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int t, input logic pop, input logic [66:0] d);
        bus.req_valid[t] = 1'b1;
        bus.req_pop[t]   = pop;
        bus.req_trace[t] = d[0];
        if (t == 0) begin
            bus.req_data0 = d;
            bus.req_lnk0  = d[4:0];
        end else begin
            bus.req_data1 = d;
            bus.req_lnk1  = d[4:0];
        end
    endtask

    task automatic idle();
        bus.req_valid = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]  rdy;
        logic [66:0] d0, d1, exp0, exp1;
        logic        saw_full;

        bus.except        = 1'b0;
        bus.except_thread = 1'b0;
        bus.req_valid     = 2'b00;
        bus.req_pop       = 2'b00;
        bus.req_data0     = '0;
        bus.req_data1     = '0;
        bus.req_lnk0      = '0;
        bus.req_lnk1      = '0;
        bus.req_trace     = 2'b00;
        tick();
        tick();
        chk("rst_ready", bus.req_ready, 2'b11);
        chk("rst_depth0", bus.depth0, 0);
        chk("rst_depth1", bus.depth1, 0);
        chk("rst_wen", bus.stk_write_wen, 0);
        chk("rst_rd", bus.stk_read_clkEn, 0);
        chk("rst_rsp", bus.rsp_valid, 0);
        chk("rst_exc", bus.stk_except, 0);
        rst = 1'b0;

        // thread 0: three pushes then four pops
        drv(0, 1'b0, 67'd1); tick();
        chk("p_e1_wen", bus.stk_write_wen, 0);
        drv(0, 1'b0, 67'd2); tick();
        chk("p1_wen", bus.stk_write_wen, 1);
        chk("p1_data", bus.stk_write_data, 1);
        chk("p1_thr", bus.stk_thread, 0);
        chk("p1_depth0", bus.depth0, 1);
        drv(0, 1'b0, 67'd3); tick();
        chk("p2_data", bus.stk_write_data, 2);
        chk("p2_depth0", bus.depth0, 2);
        idle(); tick();
        chk("p3_data", bus.stk_write_data, 3);
        chk("p3_lnk", bus.stk_write_lnk, 3);
        chk("p3_trace", bus.stk_write_trace, 1);
        chk("p3_depth0", bus.depth0, 3);
        tick();
        chk("p_idle_wen", bus.stk_write_wen, 0);
        chk("p_idle_depth0", bus.depth0, 3);

        drv(0, 1'b1, 67'd0); tick();
        chk("q_e1_rd", bus.stk_read_clkEn, 0);
        tick();
        chk("q1_rd", bus.stk_read_clkEn, 1);
        chk("q1_wen", bus.stk_write_wen, 0);
        chk("q1_depth0", bus.depth0, 2);
        tick();
        chk("q1_rsp_vld", bus.rsp_valid, 1);
        chk("q1_rsp_hit", bus.rsp_hit, 1);
        chk("q1_rsp_thr", bus.rsp_thread, 0);
        chk("q2_depth0", bus.depth0, 1);
        tick();
        idle();
        chk("q3_depth0", bus.depth0, 0);
        chk("q2_rsp_hit", bus.rsp_hit, 1);
        tick();
        chk("q4_rd", bus.stk_read_clkEn, 1);
        chk("q4_depth0", bus.depth0, 0);
        chk("q3_rsp_hit", bus.rsp_hit, 1);
        tick();
        chk("q4_rsp_vld", bus.rsp_valid, 1);
        chk("q4_rsp_hit", bus.rsp_hit, 0);
        chk("q_drain_rd", bus.stk_read_clkEn, 0);
        tick();
        chk("q_rsp_off", bus.rsp_valid, 0);
`ifdef RSTACK_CTL_STATS_EN
        chk("q_unf_cnt", bus.unf_cnt, 1);
        chk("q_ovf_cnt", bus.ovf_cnt, 0);
`endif

        // both threads requesting every cycle: strict alternation starting at thread 0
        do_reset();
        drv(0, 1'b0, 67'h10);
        drv(1, 1'b0, 67'h20);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("alt%0d_wen", i), bus.stk_write_wen, 1);
            chk($sformatf("alt%0d_thr", i), bus.stk_thread, i & 1);
        end
        chk("alt_depth0", bus.depth0, 4);
        chk("alt_depth1", bus.depth1, 4);

        // reset while both FIFOs still hold ops
        idle();
        rst = 1'b1;
        tick();
        chk("mrst_ready", bus.req_ready, 2'b11);
        chk("mrst_depth0", bus.depth0, 0);
        chk("mrst_depth1", bus.depth1, 0);
        chk("mrst_wen", bus.stk_write_wen, 0);
        chk("mrst_thr", bus.stk_thread, 0);
        chk("mrst_data", bus.stk_write_data, 0);
        rst = 1'b0;
        tick();
        chk("mrst_after_wen", bus.stk_write_wen, 0);
        chk("mrst_after_rd", bus.stk_read_clkEn, 0);

        // 17 pushes on thread 1: depth saturates at 16
        drv(1, 1'b0, 67'h30);
        tick();
        for (int k = 1; k <= 17; k++) begin
            if (k == 17) idle();
            tick();
            chk($sformatf("sat%0d_depth1", k), bus.depth1, (k > 16) ? 16 : k);
        end
        chk("sat_thr", bus.stk_thread, 1);
`ifdef RSTACK_CTL_STATS_EN
        chk("sat_ovf_cnt", bus.ovf_cnt, 1);
`endif

        // backpressure: thread 0 FIFO fills, requests held until accepted, none lost
        do_reset();
        d0 = 67'd1; d1 = 67'd1; exp0 = 67'd1; exp1 = 67'd1; saw_full = 1'b0;
        for (int i = 0; i < 26; i++) begin
            rdy = bus.req_ready;
            if (i < 20) begin
                drv(0, 1'b0, d0);
                drv(1, 1'b0, 67'h100 + d1);
            end else begin
                idle();
            end
            tick();
            if (i < 20) begin
                if (rdy[0]) d0 = d0 + 1;
                else        saw_full = 1'b1;
                if (rdy[1]) d1 = d1 + 1;
            end
            if (bus.stk_write_wen) begin
                if (bus.stk_thread == 1'b0) begin
                    chk("bp_t0_data", bus.stk_write_data, exp0);
                    exp0 = exp0 + 1;
                end else begin
                    chk("bp_t1_data", bus.stk_write_data, 67'h100 + exp1);
                    exp1 = exp1 + 1;
                end
            end
        end
        chk("bp_saw_full", saw_full, 1);
        chk("bp_t0_count", exp0, d0);
        chk("bp_t1_count", exp1, d1);

        // flush of thread 1 with two ops queued and depth1 = 5
        do_reset();
        drv(1, 1'b0, 67'h40);
        for (int i = 0; i < 5; i++) tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("fl_setup_depth1", bus.depth1, 5);
        drv(0, 1'b0, 67'hA1);
        drv(1, 1'b0, 67'hE1);
        tick();
        drv(0, 1'b0, 67'hA2);
        drv(1, 1'b0, 67'hE2);
        tick();
        chk("fl_pre_data", bus.stk_write_data, 67'hA1);
        chk("fl_pre_thr", bus.stk_thread, 0);
        chk("fl_pre_depth0", bus.depth0, 1);
        idle();
        bus.except        = 1'b1;
        bus.except_thread = 1'b1;
        tick();
        bus.except = 1'b0;
        chk("fl_exc", bus.stk_except, 1);
        chk("fl_exc_thr", bus.stk_except_thread, 1);
        chk("fl_exc_wen", bus.stk_write_wen, 0);
        chk("fl_exc_rd", bus.stk_read_clkEn, 0);
        chk("fl_depth1", bus.depth1, 0);
        chk("fl_depth0", bus.depth0, 1);
        tick();
        chk("fl_post_exc", bus.stk_except, 0);
        chk("fl_post_wen", bus.stk_write_wen, 1);
        chk("fl_post_thr", bus.stk_thread, 0);
        chk("fl_post_data", bus.stk_write_data, 67'hA2);
        chk("fl_post_depth0", bus.depth0, 2);
        tick();
        chk("fl_end_wen", bus.stk_write_wen, 0);
        chk("fl_end_rd", bus.stk_read_clkEn, 0);
        chk("fl_end_depth1", bus.depth1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
